// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: control inputs, incrementer loop, instruction memory port and IF/ID outputs.
// The o_misaligned signal only exists when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if #(
  parameter int unsigned len = 32
);
  logic           i_enable;
  logic           i_stall;
  logic           i_branch_taken;
  logic [len-1:0] i_branch_target;
  logic           i_jump;
  logic [len-1:0] i_jump_target;
  logic [len-1:0] o_pc_adder;
  logic [len-1:0] i_pc_adder;
  logic [len-1:0] o_imem_addr;
  logic [len-1:0] i_imem_data;
  logic [len-1:0] o_instruction;
  logic [len-1:0] o_pc_plus4;
  logic           o_valid;
  logic           o_halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic           o_misaligned;
`endif

  // Fetch unit side
  modport master (
    input  i_enable,
    input  i_stall,
    input  i_branch_taken,
    input  i_branch_target,
    input  i_jump,
    input  i_jump_target,
    input  i_pc_adder,
    input  i_imem_data,
    output o_pc_adder,
    output o_imem_addr,
    output o_instruction,
    output o_pc_plus4,
    output o_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output o_misaligned,
`endif
    output o_halted
  );

  // Surrounding pipeline / memory side
  modport slave (
    output i_enable,
    output i_stall,
    output i_branch_taken,
    output i_branch_target,
    output i_jump,
    output i_jump_target,
    output i_pc_adder,
    output i_imem_data,
    input  o_pc_adder,
    input  o_imem_addr,
    input  o_instruction,
    input  o_pc_plus4,
    input  o_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    input  o_misaligned,
`endif
    input  o_halted
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS instruction-fetch stage: PC register, next-PC selection (sequential / branch / jump),
// IF/ID pipeline register, stall/freeze handling and HALT detection.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (forces redirect targets word-aligned and
// raises a sticky o_misaligned flag).
module fetch_pc_unit #(
  parameter int unsigned    len       = 32,
  parameter logic [len-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input logic             i_clk,
  input logic             i_reset,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e         state_q, state_d;
  logic [len-1:0] pc_q, pc_d;
  logic [len-1:0] instr_q, instr_d;
  logic [len-1:0] pc_plus4_q, pc_plus4_d;
  logic           valid_q, valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic           misaligned_q, misaligned_d;
`endif

  logic           redirect;
  logic [len-1:0] redirect_target;

  // Branch outranks jump when both resolve in the same cycle
  always_comb begin
    redirect        = bus.i_branch_taken | bus.i_jump;
    redirect_target = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;
  end

  // Next-state: enable freeze > redirect > stall > sequential/halted behaviour
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif

    if (bus.i_enable) begin
      if (redirect) begin
        // Redirect also cancels a wrong-path HALT
`ifdef FETCH_ALIGN_CHECK_EN
        pc_d         = {redirect_target[len-1:2], 2'b00};
        misaligned_d = misaligned_q | (redirect_target[1:0] != 2'b00);
`else
        pc_d         = redirect_target;
`endif
        instr_d      = '0;
        valid_d      = 1'b0;
        state_d      = StRun;
      end else if (bus.i_stall) begin
        // hold PC and IF/ID
      end else begin
        unique case (state_q)
          StRun: begin
            instr_d    = bus.i_imem_data;
            pc_plus4_d = bus.i_pc_adder;
            valid_d    = 1'b1;
            if (bus.i_imem_data == HALT_WORD) begin
              // HALT enters IF/ID but the PC stays on it
              state_d = StHalted;
            end else begin
              pc_d = bus.i_pc_adder;
            end
          end
          StHalted: begin
            instr_d = '0;
            valid_d = 1'b0;
          end
          default: state_d = StRun;
        endcase
      end
    end
  end

  // State and IF/ID register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StRun;
      pc_q       <= '0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Outputs are direct register copies
  always_comb begin
    bus.o_pc_adder    = pc_q;
    bus.o_imem_addr   = pc_q;
    bus.o_instruction = instr_q;
    bus.o_pc_plus4    = pc_plus4_q;
    bus.o_valid       = valid_q;
    bus.o_halted      = (state_q == StHalted);
`ifdef FETCH_ALIGN_CHECK_EN
    bus.o_misaligned  = misaligned_q;
`endif
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then randomized traffic,
// compared every cycle against a per-edge behavioural model of the fetch stage.
module tb_fetch_pc_unit;
  localparam logic [31:0] Halt = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.len(32)) bus ();

  fetch_pc_unit #(.len(32), .HALT_WORD(Halt)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  // 256-word instruction memory and the external +4 incrementer
  logic [31:0] mem [256];
  assign bus.i_imem_data = mem[bus.o_imem_addr[9:2]];
  assign bus.i_pc_adder  = bus.o_pc_adder + 32'd4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_halted, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_adder", bus.o_pc_adder, m_pc);
    chk("imem_addr", bus.o_imem_addr, m_pc);
    chk("instruction", bus.o_instruction, m_instr);
    chk("pc_plus4", bus.o_pc_plus4, m_pp4);
    chk("valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, bus.o_halted}, {31'd0, m_halted});
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misaligned", {31'd0, bus.o_misaligned}, {31'd0, m_mis});
`endif
  endtask

  // One clock: drive inputs, advance the model by the stage's rules, sample after the edge
  task automatic step(input logic r, input logic en, input logic st, input logic br,
                      input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] tgt;
    logic [31:0] w;
    rst                 = r;
    bus.i_enable        = en;
    bus.i_stall         = st;
    bus.i_branch_taken  = br;
    bus.i_branch_target = bt;
    bus.i_jump          = jp;
    bus.i_jump_target   = jt;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0; m_mis = 0;
    end else if (!en) begin
      // frozen
    end else if (br || jp) begin
      tgt = br ? bt : jt;
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt % 4 != 0) m_mis = 1;
      tgt = tgt - (tgt % 4);
`endif
      m_pc = tgt; m_instr = 0; m_valid = 0; m_halted = 0;
    end else if (st) begin
      // stalled
    end else if (!m_halted) begin
      w = mem[(m_pc / 4) % 256];
      m_instr = w; m_pp4 = m_pc + 4; m_valid = 1;
      if (w == Halt) m_halted = 1;
      else m_pc = m_pc + 4;
    end else begin
      m_instr = 0; m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0; m_mis = 0;

    // Reset
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("reset_addr", bus.o_imem_addr, 32'd0);
    chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);

    // Sequential fetch: {0,4},{1,8}
    seq(1);
    chk("seq1_instr", bus.o_instruction, 32'd0);
    chk("seq1_pp4", bus.o_pc_plus4, 32'd4);
    chk("seq1_addr", bus.o_imem_addr, 32'd4);
    seq(1);
    chk("seq2_instr", bus.o_instruction, 32'd1);
    chk("seq2_addr", bus.o_imem_addr, 32'd8);

    // Stall 3 cycles at PC=8, then resume
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_addr", bus.o_imem_addr, 32'd8);
    seq(1);
    chk("resume_addr", bus.o_imem_addr, 32'd12);
    chk("resume_instr", bus.o_instruction, 32'd2);

    // Enable low window, with redirect inputs that must be ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200);
    chk("freeze_addr", bus.o_imem_addr, 32'd12);
    seq(1);

    // Branch and jump together: branch wins
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    chk("br_addr", bus.o_imem_addr, 32'h40);
    chk("br_bubble", {31'd0, bus.o_valid}, 32'd0);
    seq(1);
    chk("br_instr", bus.o_instruction, 32'h10);
    chk("br_pp4", bus.o_pc_plus4, 32'h44);

    // HALT at 0x10, then recover with branch to 0
    mem[4] = Halt;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0);
    seq(5);
    chk("halt_flag", {31'd0, bus.o_halted}, 32'd1);
    chk("halt_instr", bus.o_instruction, Halt);
    chk("halt_pc", bus.o_imem_addr, 32'h10);
    seq(2);
    chk("halt_bubble", {31'd0, bus.o_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'd0);
    chk("unhalt", {31'd0, bus.o_halted}, 32'd0);
    seq(6);

    // Reset while stalled in HALTED
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rst_halt", {31'd0, bus.o_halted}, 32'd0);
    chk("rst_instr", bus.o_instruction, 32'd0);
    seq(2);

`ifdef FETCH_ALIGN_CHECK_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h22);
    chk("align_pc", bus.o_imem_addr, 32'h20);
    seq(3);
    chk("align_sticky", {31'd0, bus.o_misaligned}, 32'd1);
`endif

    // Randomized traffic over random memory contents with occasional HALT words
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? Halt : $urandom;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] bt, jt;
      bt = $urandom_range(0, 1023);
      jt = $urandom_range(0, 1023);
`ifndef FETCH_ALIGN_CHECK_EN
      bt[1:0] = 2'b00;
      jt[1:0] = 2'b00;
`endif
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, bt, $urandom_range(0, 9) == 0, jt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the MIPS pipeline: holds the program counter, drives instruction-memory address and the PC incrementer, and selects the next PC from sequential, branch or jump targets. Registers the fetched instruction and PC+4 into the IF/ID pipeline register. Handles stalls from the hazard unit, flushes on redirect and HALT detection. Frozen by the debug unit's step enable. The incrementer is the existing adder module, instantiated outside this block with `i_b` tied to 4.

## Interface
- `len`, 32, datapath/address width in bits
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch
- `i_clk`  in  1  clock; all state changes on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_enable`  in  1  debug-unit step/run enable; 0 freezes all state
- `i_stall`  in  1  hazard-unit stall; holds PC and IF/ID
- `i_branch_taken`  in  1  taken branch resolved downstream
- `i_branch_target`  in  len  branch target address
- `i_jump`  in  1  jump decoded downstream
- `i_jump_target`  in  len  jump target address
- `o_pc_adder`  out  len  current PC, to incrementer `i_a`
- `i_pc_adder`  in  len  incrementer result (PC+4)
- `o_imem_addr`  out  len  instruction memory address (= PC)
- `i_imem_data`  in  len  instruction word, combinational read of `o_imem_addr`
- `o_instruction`  out  len  IF/ID instruction
- `o_pc_plus4`  out  len  IF/ID PC+4
- `o_valid`  out  1  IF/ID holds a real instruction (0 = bubble)
- `o_halted`  out  1  HALT fetched; sequential fetch stopped
- `o_misaligned`  out  1  only with `FETCH_ALIGN_CHECK_EN`

## Operation
- States: RUN, HALTED. Reset -> RUN.
- Reset values: PC = 0, `o_instruction` = 0, `o_pc_plus4` = 0, `o_valid` = 0, `o_halted` = 0, `o_misaligned` = 0.
- `o_pc_adder` and `o_imem_addr` are combinational copies of the PC register.
- Priority per edge: reset > `i_enable`=0 (hold everything, ignore all inputs) > branch > jump > stall > sequential.
- Branch and jump asserted together: branch wins; PC <- `i_branch_target`.
- Redirect (branch or jump): PC <- target. IF/ID <- bubble (`o_valid`=0, `o_instruction`=0, `o_pc_plus4` unchanged). A redirect overrides a simultaneous stall.
- Stall, no redirect: PC and IF/ID hold their values.
- Sequential in RUN: PC <- `i_pc_adder`. IF/ID <- {`i_imem_data`, `i_pc_adder`, valid=1}.
- HALT detect: a sequential load with `i_imem_data` == `HALT_WORD` loads IF/ID normally (valid=1) and holds the PC. State -> HALTED, `o_halted` <- 1.
- HALTED: PC holds. IF/ID loads bubbles (`o_valid`=0).
- HALTED with redirect: the HALT came from the wrong path. Apply the redirect, state -> RUN, `o_halted` <- 0.
- HALTED exits otherwise only on reset.
- PC wraps modulo 2^len through the incrementer. No special handling.

## Timing
- Fetch latency 1 cycle: the word at PC appears on `o_instruction` the edge after PC is presented.
- Redirect asserted in cycle n: `o_imem_addr` = target in n+1. The target instruction is on `o_instruction` in n+2. Bubble in n+1.
- `o_halted` rises the same edge HALT enters IF/ID.
- Stall/enable are level-sensitive, sampled each edge. No handshake.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect target with bits [1:0] != 0 loads PC with bits [1:0] forced to 0.
  - `o_misaligned` is set (sticky until reset).
  - The IF/ID bubble is inserted as usual.
- Not defined:
  - Targets are loaded unmodified.
  - `o_misaligned` is absent from the port list.

## Test plan
- Reset, enable=1, memory word k = k: `o_imem_addr` steps 0,4,8,12. `o_instruction`/`o_pc_plus4` = {0,4},{1,8},{2,12}. `o_valid`=1 from cycle 1.
- Stall 3 cycles at PC=8: PC and IF/ID frozen 3 cycles, then resume at 12. The enable=0 window behaves identically.
- Branch to 0x40 and jump to 0x80 in the same cycle: PC=0x40, one bubble, then word 0x40/4 with `o_pc_plus4`=0x44.
- HALT_WORD at 0x10: IF/ID = HALT, valid=1, `o_halted`=1. PC stays 0x10 and the following cycles are bubbles. Then branch to 0x00 -> `o_halted`=0 and fetch restarts at 0.
- Reset asserted mid-stall in HALTED: all outputs return to reset values the next edge. Fetch restarts at 0.
- `FETCH_ALIGN_CHECK_EN`: jump to 0x22 -> PC=0x20, `o_misaligned`=1 and held through later fetches.
